// File: rtl/tmds_encoder_pipe.sv
// tmds_encoder_pipe
// Pipelined multi-lane TMDS (DVI 8b/10b) encoder. Each lane has a registered
// transition-minimisation stage followed by a registered DC-balance stage
// that owns its own running-disparity counter. Control periods (de=0) emit
// the four DVI control tokens and clear that lane's disparity.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst        asynchronous active-high reset
//   s_rst      synchronous clear, same effect as rst
//   valid_in   input word qualifier
//   de_in      data enable shared by all lanes (1 = video, 0 = control)
//   data_in    lane k pixel byte at [8k+7:8k]
//   ctrl_in    lane k control pair {C1,C0} at [2k+1:2k]
//   sym_out    lane k 10-bit symbol at [10k+9:10k], held across bubbles
//   valid_out  sym_out qualifier, two clocks after valid_in
module tmds_encoder_pipe #(
  parameter int NUM_CH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_rst,
  input  logic                  valid_in,
  input  logic                  de_in,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [2*NUM_CH-1:0]   ctrl_in,
  output logic [10*NUM_CH-1:0]  sym_out,
  output logic                  valid_out
);

  // Number of ones in a byte.
  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

  // Transition-minimised 9-bit word; bit 8 = 1 marks the XOR form.
  function automatic logic [8:0] tm_word(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcnt8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && (d[0] == 1'b0));
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

  logic [NUM_CH-1:0][8:0] r_q1;
  logic [2*NUM_CH-1:0]    r_ctrl1;
  logic                   r_de1;
  logic                   r_v1;
  logic                   r_vout;

  // Stage 1: transition minimisation, registered with de/ctrl/valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q1    <= '0;
      r_ctrl1 <= '0;
      r_de1   <= 1'b0;
      r_v1    <= 1'b0;
    end else if (s_rst) begin
      r_q1    <= '0;
      r_ctrl1 <= '0;
      r_de1   <= 1'b0;
      r_v1    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_q1[k] <= tm_word(data_in[8*k +: 8]);
      end
      r_ctrl1 <= ctrl_in;
      r_de1   <= de_in;
      r_v1    <= valid_in;
    end
  end

  // Output qualifier follows the stage-1 valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vout <= 1'b0;
    end else if (s_rst) begin
      r_vout <= 1'b0;
    end else begin
      r_vout <= r_v1;
    end
  end

  assign valid_out = r_vout;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic signed [5:0] r_cnt;
    logic [9:0]        r_sym;
    logic [9:0]        w_sym;
    logic signed [5:0] w_delta;
    logic [3:0]        w_n1;
    logic [3:0]        w_n0;
    logic signed [5:0] w_d10;
    logic              w_q8;
    logic              w_inv;
    logic [7:0]        w_q;

    // Stage 2: DC-balance decision and disparity delta for this lane.
    always_comb begin
      w_q     = r_q1[k][7:0];
      w_q8    = r_q1[k][8];
      w_n1    = popcnt8(w_q);
      w_n0    = 4'd8 - w_n1;
      // Popcounts are zero-extended so the subtraction is done signed.
      w_d10   = $signed({2'b00, w_n1}) - $signed({2'b00, w_n0});
      w_inv   = 1'b0;
      w_delta = 6'sd0;
      w_sym   = 10'd0;
      if (r_de1) begin
        if ((r_cnt == 6'sd0) || (w_n1 == w_n0)) begin
          w_inv   = ~w_q8;
          w_delta = w_q8 ? w_d10 : -w_d10;
        end else if (((r_cnt > 6'sd0) && (w_n1 > w_n0)) ||
                     ((r_cnt < 6'sd0) && (w_n0 > w_n1))) begin
          w_inv   = 1'b1;
          w_delta = $signed({4'b0000, w_q8, 1'b0}) - w_d10;
        end else begin
          w_inv   = 1'b0;
          w_delta = w_d10 - $signed({4'b0000, ~w_q8, 1'b0});
        end
        w_sym = {w_inv, w_q8, (w_inv ? ~w_q : w_q)};
      end else begin
        case (r_ctrl1[2*k +: 2])
          2'b00:   w_sym = 10'b1101010100;
          2'b01:   w_sym = 10'b0010101011;
          2'b10:   w_sym = 10'b0101010100;
          2'b11:   w_sym = 10'b1010101011;
          default: w_sym = 10'b1101010100;
        endcase
      end
    end

    // Symbol and disparity registers; both hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sym <= 10'd0;
        r_cnt <= 6'sd0;
      end else if (s_rst) begin
        r_sym <= 10'd0;
        r_cnt <= 6'sd0;
      end else if (r_v1) begin
        r_sym <= w_sym;
        r_cnt <= r_de1 ? (r_cnt + w_delta) : 6'sd0;
      end else begin
        r_sym <= r_sym;
        r_cnt <= r_cnt;
      end
    end

    assign sym_out[10*k +: 10] = r_sym;
  end

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Self-checking bench for tmds_encoder_pipe (3 lanes). A per-lane integer
// reference model of the DVI encoding rules predicts every output symbol;
// directed steps also compare lane 0 against known constant symbols.
module tb_tmds_encoder_pipe;
  localparam int NC = 3;

  logic            clk;
  logic            rst;
  logic            s_rst;
  logic            valid_in;
  logic            de_in;
  logic [8*NC-1:0] data_in;
  logic [2*NC-1:0] ctrl_in;
  logic [10*NC-1:0] sym_out;
  logic            valid_out;

  int checks;
  int errors;

  // Reference model state.
  int              mcnt [NC];
  logic            pend_v;
  logic [10*NC-1:0] pend_sym;
  logic            exp_v;
  logic [10*NC-1:0] last_sym;

  tmds_encoder_pipe #(.NUM_CH(NC)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_rst     (s_rst),
    .valid_in  (valid_in),
    .de_in     (de_in),
    .data_in   (data_in),
    .ctrl_in   (ctrl_in),
    .sym_out   (sym_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encode one word of lane k from the encoding rules, updating its disparity.
  function automatic logic [9:0] ref_lane(input int k, input logic [7:0] d,
                                          input logic de, input logic [1:0] c);
    int   n1, ones, zeros, q8, inv;
    int   q [8];
    logic [9:0] s;
    if (!de) begin
      mcnt[k] = 0;
      case (c)
        2'd0:    return 10'h354;
        2'd1:    return 10'h0AB;
        2'd2:    return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(d[i]);
    q8 = ((n1 > 4) || (n1 == 4 && d[0] == 1'b0)) ? 0 : 1;
    q[0] = int'(d[0]);
    for (int i = 1; i < 8; i++) begin
      if (q8 == 1) q[i] = (q[i-1] != int'(d[i])) ? 1 : 0;
      else         q[i] = (q[i-1] == int'(d[i])) ? 1 : 0;
    end
    ones = 0;
    for (int i = 0; i < 8; i++) ones += q[i];
    zeros = 8 - ones;
    if (mcnt[k] == 0 || ones == zeros) begin
      inv = 1 - q8;
      mcnt[k] += (q8 == 1) ? (ones - zeros) : (zeros - ones);
    end else if ((mcnt[k] > 0 && ones > zeros) || (mcnt[k] < 0 && zeros > ones)) begin
      inv = 1;
      mcnt[k] += 2 * q8 + zeros - ones;
    end else begin
      inv = 0;
      mcnt[k] += -2 * (1 - q8) + ones - zeros;
    end
    s[9] = (inv == 1);
    s[8] = (q8 == 1);
    for (int i = 0; i < 8; i++) s[i] = ((q[i] ^ inv) == 1);
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NC; k++) mcnt[k] = 0;
    pend_v   = 1'b0;
    pend_sym = '0;
    exp_v    = 1'b0;
    last_sym = '0;
  endfunction

  // Drive one word, clock once, and compare outputs against the model.
  task automatic tick(input logic v, input logic de, input logic [23:0] d,
                      input logic [5:0] c, input logic sr);
    logic [10*NC-1:0] w;
    valid_in = v;
    de_in    = de;
    data_in  = d;
    ctrl_in  = c;
    s_rst    = sr;
    w = '0;
    if (v && !sr) begin
      for (int k = 0; k < NC; k++) w[10*k +: 10] = ref_lane(k, d[8*k +: 8], de, c[2*k +: 2]);
    end
    @(posedge clk);
    #1;
    if (sr) begin
      model_clear();
    end else begin
      exp_v = pend_v;
      if (pend_v) last_sym = pend_sym;
      pend_v   = v;
      pend_sym = w;
    end
    s_rst = 1'b0;
    chk("valid_out", {29'd0, valid_out}, {29'd0, exp_v});
    chk("sym_out", sym_out, last_sym);
  endtask

  initial begin
    logic [31:0] r;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    s_rst    = 1'b0;
    valid_in = 1'b0;
    de_in    = 1'b0;
    data_in  = '0;
    ctrl_in  = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sym", sym_out, 30'd0);
    chk("reset_valid", {29'd0, valid_out}, 30'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two 0x00 words on a fresh lane: 0x100 (cnt -8) then 0x3FF (cnt +2).
    tick(1'b1, 1'b1, 24'h123400, 6'd0, 1'b0);
    chk("first_lat_valid", {29'd0, valid_out}, 30'd0);
    tick(1'b1, 1'b1, 24'hA5C300, 6'd0, 1'b0);
    chk("zero_a", {20'd0, sym_out[9:0]}, 30'h100);
    tick(1'b0, 1'b1, 24'h000000, 6'd0, 1'b0);
    chk("zero_b", {20'd0, sym_out[9:0]}, 30'h3FF);
    chk("zero_b_valid", {29'd0, valid_out}, 30'd1);

    // Control tokens on every lane, then a 0x00 word proves cnt was cleared.
    tick(1'b1, 1'b0, 24'h0, 6'b000000, 1'b0);
    tick(1'b1, 1'b0, 24'h0, 6'b010101, 1'b0);
    chk("tok00", {20'd0, sym_out[9:0]}, 30'h354);
    tick(1'b1, 1'b0, 24'h0, 6'b101010, 1'b0);
    chk("tok01", {20'd0, sym_out[9:0]}, 30'h0AB);
    tick(1'b1, 1'b0, 24'h0, 6'b111111, 1'b0);
    chk("tok10", {20'd0, sym_out[9:0]}, 30'h154);
    tick(1'b1, 1'b1, 24'h000000, 6'd0, 1'b0);
    chk("tok11", {20'd0, sym_out[9:0]}, 30'h2AB);
    chk("tok11_lane2", {20'd0, sym_out[29:20]}, 30'h2AB);
    tick(1'b1, 1'b0, 24'h0, 6'd0, 1'b0);
    chk("cnt_cleared", {20'd0, sym_out[9:0]}, 30'h100);

    // 0xFF then 0x55 after a control word (fresh cnt).
    tick(1'b1, 1'b1, 24'h3C81FF, 6'd0, 1'b0);
    tick(1'b1, 1'b1, 24'h7E0F55, 6'd0, 1'b0);
    chk("ff_word", {20'd0, sym_out[9:0]}, 30'h200);
    tick(1'b1, 1'b0, 24'h0, 6'd0, 1'b0);
    chk("x55_word", {20'd0, sym_out[9:0]}, 30'h133);

    // Bubble between two 0x00 words: output holds, disparity unaffected.
    tick(1'b1, 1'b1, 24'h000000, 6'd0, 1'b0);
    chk("bub_tok", {20'd0, sym_out[9:0]}, 30'h354);
    tick(1'b0, 1'b1, 24'hFFFFFF, 6'd0, 1'b0);
    chk("bub_v1", {29'd0, valid_out}, 30'd1);
    chk("bub_a", {20'd0, sym_out[9:0]}, 30'h100);
    tick(1'b1, 1'b1, 24'h000000, 6'd0, 1'b0);
    chk("bub_v0", {29'd0, valid_out}, 30'd0);
    chk("bub_hold", {20'd0, sym_out[9:0]}, 30'h100);
    tick(1'b0, 1'b1, 24'h0, 6'd0, 1'b0);
    chk("bub_v2", {29'd0, valid_out}, 30'd1);
    chk("bub_b", {20'd0, sym_out[9:0]}, 30'h3FF);

    // Asynchronous reset mid-stream, checked between clock edges.
    tick(1'b1, 1'b1, 24'h5A3C99, 6'd0, 1'b0);
    tick(1'b1, 1'b1, 24'h11EE42, 6'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sym", sym_out, 30'd0);
    chk("arst_valid", {29'd0, valid_out}, 30'd0);
    #1;
    rst = 1'b0;
    model_clear();
    tick(1'b0, 1'b1, 24'h0, 6'd0, 1'b0);
    chk("arst_drop", {29'd0, valid_out}, 30'd0);

    // Synchronous clear overriding a valid word.
    tick(1'b1, 1'b1, 24'h0F0F0F, 6'd0, 1'b0);
    tick(1'b1, 1'b1, 24'hF0F0F0, 6'd0, 1'b0);
    tick(1'b1, 1'b1, 24'h777777, 6'd0, 1'b1);
    chk("srst_sym", sym_out, 30'd0);
    tick(1'b1, 1'b1, 24'h000000, 6'd0, 1'b0);
    chk("srst_dropped", {29'd0, valid_out}, 30'd0);
    tick(1'b0, 1'b1, 24'h0, 6'd0, 1'b0);
    chk("srst_cnt0", {20'd0, sym_out[9:0]}, 30'h100);

    // Randomized traffic: bubbles, de transitions, occasional sync clear.
    for (int n = 0; n < 400; n++) begin
      logic v, de, sr;
      logic [23:0] d;
      logic [5:0]  c;
      r  = $urandom;
      d  = r[23:0];
      r  = $urandom;
      c  = r[5:0];
      v  = (r[9:8] != 2'b00);
      de = (r[13:10] != 4'd0);
      sr = (r[21:16] == 6'd0);
      tick(v, de, d, c, sr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
